// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared types, command field positions and control word helper for spi_slave_cmd_seq
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_PUSH
    } spi_cmd_state_e;

    localparam int CMD_WR_BIT   = 31;
    localparam int CMD_LEN_MSB  = 23;
    localparam int CMD_LEN_LSB  = 16;
    localparam int CMD_ADDR_MSB = 15;
    localparam int CMD_ADDR_LSB = 0;

    // Word length field 31 selects 32-bit SPI words.
    function automatic logic [15:0] spi_ctrl_word(input logic cpol, input logic cpha);
        return {5'd31, 6'd0, cpha, cpol, 3'd0};
    endfunction

endpackage

// File: rtl/spi_slave_cmd_seq.sv
// rtl/spi_slave_cmd_seq.sv - SPI word to register-bus burst sequencer; bus watchdog under SPI_CMD_SEQ_TIMEOUT_EN
module spi_slave_cmd_seq
    import spi_cmd_pkg::*;
#(
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [15:0] control,
    input  logic [31:0] rx_data,
    input  logic        rx_data_valid,
    output logic [31:0] tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    input  logic        tx_error,
    output logic        reg_req,
    output logic        reg_we,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdata,
    output logic        busy,
    output logic        err_ovf,
    output logic        err_underrun,
    output logic        err_timeout,
    input  logic        err_clr
);

    spi_cmd_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] txd_q, txd_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_q, hold_d;
    logic        req_q, we_q, txv_q, busy_q, ovf_q, udr_q;
    logic [15:0] ctrl_q;
    logic        ovf_set, tmo, ack;
    logic        word_v;
    logic [31:0] word;

    assign ack    = reg_ack & req_q;
    assign word_v = hold_v_q | rx_data_valid;
    assign word   = hold_v_q ? hold_q : rx_data;

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        tmo_err_q;

    assign tmo         = req_q & ~reg_ack & (wd_q == 16'(TIMEOUT_CYC - 1));
    assign err_timeout = tmo_err_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wd_q      <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wd_q      <= (req_q && !reg_ack && !tmo) ? wd_q + 16'd1 : 16'd0;
            tmo_err_q <= tmo | (tmo_err_q & ~err_clr);
        end
    end
`else
    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        txd_d    = txd_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        ovf_set  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (word_v) begin
                    cnt_d   = word[CMD_LEN_MSB:CMD_LEN_LSB];
                    addr_d  = word[CMD_ADDR_MSB:CMD_ADDR_LSB];
                    state_d = word[CMD_WR_BIT] ? ST_WR_DATA : ST_RD_REQ;
                end
            end
            ST_WR_DATA: begin
                if (word_v) begin
                    wdata_d = word;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (ack) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_q + 16'd1;
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_RD_REQ: begin
                if (ack) begin
                    txd_d   = reg_rdata;
                    state_d = ST_RD_PUSH;
                end
            end
            ST_RD_PUSH: begin
                if (txv_q && tx_data_ready) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        addr_d  = addr_q + 16'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tmo) begin
            state_d = ST_IDLE;
        end

        // The held word is consumed in IDLE/WR_DATA; a pulse in that same cycle refills it.
        if (state_q == ST_IDLE || state_q == ST_WR_DATA) begin
            if (hold_v_q) begin
                hold_v_d = rx_data_valid;
                hold_d   = rx_data;
            end
        end else if (rx_data_valid) begin
            if (hold_v_q) begin
                ovf_set = 1'b1;
            end else begin
                hold_v_d = 1'b1;
                hold_d   = rx_data;
            end
        end

        // Words received during a read burst are master dummies, never commands.
        if ((state_q == ST_RD_REQ || state_q == ST_RD_PUSH) && state_d == ST_IDLE) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            txd_q    <= '0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            txv_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
            ctrl_q   <= spi_ctrl_word(1'(CPOL), 1'(CPHA));
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            txd_q    <= txd_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            req_q    <= (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
            we_q     <= (state_d == ST_WR_REQ);
            txv_q    <= (state_d == ST_RD_PUSH);
            busy_q   <= (state_d != ST_IDLE);
            ovf_q    <= ovf_set | (ovf_q & ~err_clr);
            udr_q    <= tx_error | (udr_q & ~err_clr);
            ctrl_q   <= spi_ctrl_word(1'(CPOL), 1'(CPHA));
        end
    end

    assign control       = ctrl_q;
    assign tx_data       = txd_q;
    assign tx_data_valid = txv_q;
    assign reg_req       = req_q;
    assign reg_we        = we_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign busy          = busy_q;
    assign err_ovf       = ovf_q;
    assign err_underrun  = udr_q;

endmodule

// File: tb/tb_spi_slave_cmd_seq.sv
// tb/tb_spi_slave_cmd_seq.sv - scoreboard bench for spi_slave_cmd_seq; timeout case under SPI_CMD_SEQ_TIMEOUT_EN
module tb_spi_slave_cmd_seq;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] control;
    logic [31:0] rx_data = '0;
    logic        rx_data_valid = 1'b0;
    logic [31:0] tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready = 1'b1;
    logic        tx_error = 1'b0;
    logic        reg_req;
    logic        reg_we;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        ack_drv = 1'b0;
    logic        stray_ack = 1'b0;
    logic        reg_ack_w;
    logic [31:0] reg_rdata = '0;
    logic        busy;
    logic        err_ovf;
    logic        err_underrun;
    logic        err_timeout;
    logic        err_clr = 1'b0;

    assign reg_ack_w = ack_drv | stray_ack;

    always #5 sys_clk = ~sys_clk;

    spi_slave_cmd_seq #(.CPOL(1), .CPHA(0), .TIMEOUT_CYC(15)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .control(control),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
        .tx_error(tx_error), .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_ack(reg_ack_w), .reg_rdata(reg_rdata), .busy(busy),
        .err_ovf(err_ovf), .err_underrun(err_underrun), .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_tx[$];
    int checks = 0, failures = 0;
    int sent_wr = 0, n_wr_done = 0, rd_total = 0, n_rd_done = 0;
    bit no_ack = 1'b0, bp_force = 1'b0;

    function automatic bus_t mk(input logic we, input logic [15:0] a, input logic [31:0] d);
        bus_t b;
        b.we = we; b.addr = a; b.wdata = d;
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_rx(input logic [31:0] w);
        rx_data = w;
        rx_data_valid = 1'b1;
        tick();
        rx_data_valid = 1'b0;
    endtask

    task automatic wait_wr(input int lim);
        int n = 0;
        while (sent_wr - n_wr_done > lim && n < 3000) begin tick(); n++; end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL wait_writes outstanding=%0d required<=%0d", sent_wr - n_wr_done, lim);
        end
    endtask

    task automatic wait_rd(input int target);
        int n = 0;
        while (n_rd_done < target && n < 6000) begin tick(); n++; end
        if (n >= 6000) begin
            checks++; failures++;
            $display("FAIL wait_reads done=%0d required=%0d", n_rd_done, target);
        end
    endtask

    // Bus slave: random ack latency, read data is address + 0x100.
    int dly = 0;
    always begin
        @(posedge sys_clk);
        #2;
        if (sys_rst) ack_drv = 1'b0;
        else if (ack_drv) ack_drv = 1'b0;
        else if (reg_req && !no_ack) begin
            if (dly <= 0) begin
                ack_drv   = 1'b1;
                reg_rdata = {16'h0, reg_addr} + 32'h100;
                dly       = $urandom_range(0, 3);
            end else dly--;
        end
    end

    always begin
        @(posedge sys_clk);
        #2;
        tx_data_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    logic        pend = 1'b0, after_ack = 1'b0, after_rd = 1'b0;
    logic [31:0] pend_data = '0;
    bus_t        mon_e;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            pend = 1'b0;
            after_ack = 1'b0;
        end else begin
            if (after_ack) begin
                check("req_fall_after_ack", reg_req, 0);
                if (after_rd) check("txv_rise_after_ack", tx_data_valid, 1);
            end
            after_ack = 1'b0;
            if (pend) begin
                check("tx_hold_valid", tx_data_valid, 1);
                check("tx_hold_data", tx_data, pend_data);
            end
            if (reg_req && reg_ack_w) begin
                after_ack = 1'b1;
                after_rd  = !reg_we;
                if (reg_we) n_wr_done++;
                if (exp_bus.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected we=%0b addr=%h", reg_we, reg_addr);
                end else begin
                    mon_e = exp_bus.pop_front();
                    check("bus_we", reg_we, mon_e.we);
                    check("bus_addr", reg_addr, mon_e.addr);
                    if (mon_e.we) check("bus_wdata", reg_wdata, mon_e.wdata);
                end
            end
            pend      = tx_data_valid && !tx_data_ready;
            pend_data = tx_data;
            if (tx_data_valid && tx_data_ready) begin
                n_rd_done++;
                if (exp_tx.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected data=%h", tx_data);
                end else check("tx_data", tx_data, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        int len, n, rb;
        #1 sys_rst = 1'b1;
        tick(); tick();
        check("rst_req", reg_req, 0);
        check("rst_busy", busy, 0);
        check("rst_txv", tx_data_valid, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_control", control, 16'hF808);
        check("rst_errs", {err_ovf, err_underrun, err_timeout}, 0);
        sys_rst = 1'b0;
        tick();

        // Directed write burst
        exp_bus.push_back(mk(1'b1, 16'h0010, 32'hAAAA_0001));
        exp_bus.push_back(mk(1'b1, 16'h0011, 32'hAAAA_0002));
        pulse_rx(32'h8001_0010);
        check("wr_busy", busy, 1);
        check("wr_noreq_yet", reg_req, 0);
        pulse_rx(32'hAAAA_0001); sent_wr++;
        check("wr_req_lat", reg_req, 1);
        check("wr_we", reg_we, 1);
        check("wr_addr0", reg_addr, 16'h0010);
        wait_wr(1);
        pulse_rx(32'hAAAA_0002); sent_wr++;
        wait_wr(0);
        tick();
        check("wr_done_busy", busy, 0);

        // Directed read with wrap and backpressure on the second word
        rb = n_rd_done;
        exp_bus.push_back(mk(1'b0, 16'hFFFF, 0)); exp_tx.push_back(32'h0001_00FF);
        exp_bus.push_back(mk(1'b0, 16'h0000, 0)); exp_tx.push_back(32'h0000_0100);
        exp_bus.push_back(mk(1'b0, 16'h0001, 0)); exp_tx.push_back(32'h0000_0101);
        rd_total += 3;
        pulse_rx(32'h0002_FFFF);
        check("rd_req_lat", reg_req, 1);
        check("rd_we", reg_we, 0);
        check("rd_addr0", reg_addr, 16'hFFFF);
        wait_rd(rb + 1);
        bp_force = 1'b1;
        repeat (5) tick();
        bp_force = 1'b0;
        wait_rd(rd_total);
        tick();
        check("rd_done_busy", busy, 0);

        // Randomized bursts, including a full 256-word read across the wrap
        for (int k = 0; k < 30; k++) begin
            wait_wr(0);
            wait_rd(rd_total);
            repeat ($urandom_range(0, 2)) tick();
            a   = 16'($urandom);
            len = $urandom_range(0, 6);
            if (k == 10) begin len = 255; a = 16'hFF80; end
            if (k != 10 && $urandom_range(0, 1) == 1) begin
                pulse_rx({1'b1, 7'($urandom), 8'(len), a});
                for (int i = 0; i <= len; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    wait_wr(1);
                    d = $urandom;
                    exp_bus.push_back(mk(1'b1, 16'(a + i), d));
                    pulse_rx(d); sent_wr++;
                end
            end else begin
                for (int i = 0; i <= len; i++) begin
                    exp_bus.push_back(mk(1'b0, 16'(a + i), 0));
                    exp_tx.push_back({16'h0, 16'(a + i)} + 32'h100);
                end
                rd_total += len + 1;
                pulse_rx({1'b0, 7'($urandom), 8'(len), a});
                if ($urandom_range(0, 1) == 1) pulse_rx($urandom);
            end
        end
        wait_wr(0);
        wait_rd(rd_total);
        tick();
        check("rand_bus_left", exp_bus.size(), 0);
        check("rand_tx_left", exp_tx.size(), 0);

        // Overflow during a stalled write request
        no_ack = 1'b1;
        exp_bus.push_back(mk(1'b1, 16'h2000, 32'h1111_0000));
        exp_bus.push_back(mk(1'b1, 16'h2001, 32'h2222_0000));
        pulse_rx(32'h8001_2000);
        pulse_rx(32'h1111_0000); sent_wr++;
        check("ovf_stalled_req", reg_req, 1);
        pulse_rx(32'h2222_0000); sent_wr++;
        check("ovf_not_yet", err_ovf, 0);
        pulse_rx(32'h3333_0000);
        check("ovf_set", err_ovf, 1);
        no_ack = 1'b0;
        wait_wr(0);
        tick();
        check("ovf_sticky", err_ovf, 1);
        check("ovf_idle", busy, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("ovf_clr", err_ovf, 0);

        // Underrun sticky, set wins over clear
        tx_error = 1'b1; tick(); tx_error = 1'b0;
        tick();
        check("udr_set", err_underrun, 1);
        tx_error = 1'b1; err_clr = 1'b1; tick(); tx_error = 1'b0;
        check("udr_set_wins", err_underrun, 1);
        tick(); err_clr = 1'b0;
        check("udr_clr", err_underrun, 0);

        // Stray ack while idle
        stray_ack = 1'b1; tick(); stray_ack = 1'b0; tick();
        check("stray_ack_busy", busy, 0);
        check("stray_ack_req", reg_req, 0);

        // Reset mid-burst
        no_ack = 1'b1;
        err_clr = 1'b0;
        tx_error = 1'b1; tick(); tx_error = 1'b0;
        pulse_rx(32'h8000_3000);
        pulse_rx(32'h5A5A_A5A5);
        check("mid_req", reg_req, 1);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_req", reg_req, 0);
        check("mid_rst_we", reg_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wdata", reg_wdata, 0);
        check("mid_rst_addr", reg_addr, 0);
        check("mid_rst_tx", {tx_data_valid, tx_data}, 0);
        check("mid_rst_errs", {err_ovf, err_underrun, err_timeout}, 0);
        check("mid_rst_control", control, 16'hF808);
        tick(); tick();
        sys_rst = 1'b0;
        no_ack = 1'b0;
        tick();
        exp_bus.push_back(mk(1'b0, 16'h1234, 0));
        exp_tx.push_back(32'h0000_1334);
        rd_total += 1;
        pulse_rx(32'h0000_1234);
        wait_rd(rd_total);
        tick();
        check("post_rst_idle", busy, 0);
        check("post_rst_left", exp_tx.size(), 0);

`ifdef SPI_CMD_SEQ_TIMEOUT_EN
        no_ack = 1'b1;
        pulse_rx(32'h8000_4000);
        pulse_rx(32'hDEAD_BEEF);
        n = 0;
        while (reg_req && n < 100) begin n++; tick(); end
        check("tmo_cycles", n, 15);
        check("tmo_err", err_timeout, 1);
        check("tmo_idle", busy, 0);
        no_ack = 1'b0;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("tmo_clr", err_timeout, 0);
`else
        n = 0;
        check("tmo_tied", err_timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_cmd_seq.md
# spi_slave_cmd_seq

Command sequencer on the system side of the SPI slave, clocked by `sys_clk`. It decodes 32-bit words received from the SPI master as read/write burst commands and issues them on a simple register bus. Read data is returned to the SPI slave TX FIFO for shifting out on MISO. It also drives the slave's `control` word, so the SPI mode and word length are fixed at build time.

## Interface

Parameters:
- `CPOL`, default 0: drives `control[3]`.
- `CPHA`, default 0: drives `control[4]`.
- `TIMEOUT_CYC`, default 255: bus-ack watchdog limit in `sys_clk` cycles. Used only with the configuration macro.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: asynchronous reset, active-high.
- `control` out 16: SPI slave configuration word.
- `rx_data` in 32: received word from the SPI slave.
- `rx_data_valid` in 1: one-cycle pulse, `rx_data` is valid.
- `tx_data` out 32: read data to the SPI slave TX FIFO.
- `tx_data_valid` out 1: `tx_data` is valid.
- `tx_data_ready` in 1: TX FIFO is not full.
- `tx_error` in 1: SPI slave TX underrun indication, level.
- `reg_req` out 1: bus request.
- `reg_we` out 1: 1 = write, 0 = read.
- `reg_addr` out 16: word address.
- `reg_wdata` out 32: write data.
- `reg_ack` in 1: bus completion, one cycle.
- `reg_rdata` in 32: read data, valid with `reg_ack`.
- `busy` out 1: state is not IDLE.
- `err_ovf` out 1: sticky, an RX word was dropped.
- `err_underrun` out 1: sticky, `tx_error` was seen.
- `err_timeout` out 1: sticky, a bus access timed out. Tied 0 without the macro.
- `err_clr` in 1: synchronous clear of all sticky errors.

## Operation

- `control` is `{5'd31, 6'd0, CPHA, CPOL, 3'd0}`, giving 32-bit words. It is a registered output and its reset value equals the same constant.
- Command word format:
  - `[31]` WR: 1 = write, 0 = read.
  - `[30:24]` reserved, ignored.
  - `[23:16]` LEN: the burst is LEN+1 words, 1..256.
  - `[15:0]` ADDR: start address.
- The address increments by 1 per word and wraps modulo 2^16.
- States:
  - IDLE: on `rx_data_valid`, latch the command. Go to WR_DATA if WR=1, otherwise go to RD_REQ.
  - WR_DATA: wait for `rx_data_valid`, latch the word into `reg_wdata`, go to WR_REQ.
  - WR_REQ: hold `reg_req=1`, `reg_we=1` until `reg_ack`. On ack, decrement the remaining count. Go to IDLE if the count is exhausted, otherwise go to WR_DATA.
  - RD_REQ: hold `reg_req=1`, `reg_we=0` until `reg_ack`. On ack, capture `reg_rdata` into `tx_data` and go to RD_PUSH.
  - RD_PUSH: hold `tx_data_valid` until `tx_data_ready`. Go to IDLE if this was the last word, otherwise increment the address and go to RD_REQ.
- Hold register: one entry, used while in WR_REQ, RD_REQ or RD_PUSH.
  - An RX word arriving in any of these states is held and consumed on the next entry to IDLE or WR_DATA, before any new pulse.
  - During a read burst, RX words are master dummies. They are held and discarded, and never decoded as commands.
  - An RX word arriving while the hold register is full is dropped and sets `err_ovf`.
- `tx_error` high in any cycle sets `err_underrun`.
- Stickies: `err_clr` clears them. If a set event and `err_clr` occur in the same cycle, set wins.

## Timing

- Reset values:
  - `reg_req`, `reg_we`, `tx_data_valid`, `busy`, all errors: 0.
  - `reg_addr`, `reg_wdata`, `tx_data`: 0.
  - `control`: the constant above.
  - State: IDLE.
- All outputs are registered; no combinational path exists from input to output.
- Read command with `rx_data_valid` in cycle N: `reg_req` rises in N+1.
- `reg_ack` in cycle M:
  - `reg_req` falls in M+1.
  - For a read, `tx_data_valid` rises in M+1.
- The transfer completes in the cycle where `tx_data_valid && tx_data_ready`. The next `reg_req` is asserted in the following cycle.
- Write: a data-word pulse in cycle K gives `reg_req` in K+1.
- `reg_ack` arriving while `reg_req=0` is ignored.
- Asserting `sys_rst` mid-burst aborts immediately. The partial burst is not resumed.

## Configuration

- Macro `SPI_CMD_SEQ_TIMEOUT_EN`.
- Defined:
  - An 8..16-bit counter runs while `reg_req` is high.
  - When the count reaches `TIMEOUT_CYC` without ack, drop `reg_req`, set `err_timeout` and abort the burst to IDLE.
  - The remaining write data words arriving afterwards are decoded as new commands. The master must recover by pulsing CS and resending.
- Undefined:
  - No counter.
  - The sequencer waits on `reg_ack` indefinitely.
  - `err_timeout` is constant 0.

## Structure

- Package `spi_cmd_pkg`:
  - State enum `spi_cmd_state_e`.
  - Command field positions `CMD_WR_BIT`, `CMD_LEN_MSB/LSB`, `CMD_ADDR_MSB/LSB`.
  - Function `spi_ctrl_word(cpol, cpha)` returning the 16-bit control constant.
- Single module, with no sub-module. The watchdog is a few lines inside the `ifdef`.

## Test plan

- Write burst:
  - Stimulus: cmd `0x8001_0010`, then data `0xAAAA_0001`, `0xAAAA_0002`.
  - Response: two bus writes, to addr 0x0010 and 0x0011 with that data, then IDLE with `busy=0`.
- Read burst with backpressure:
  - Stimulus: cmd `0x0002_FFFF`, `rdata` = addr+0x100, `tx_data_ready` low for 5 cycles on the 2nd word.
  - Response: reads at 0xFFFF, 0x0000, 0x0001 (wrap). `tx_data` = 0x100FF, 0x100, 0x101 in order, each held until ready.
- Overflow:
  - Stimulus: during a stalled WR_REQ, send 2 RX pulses.
  - Response: first word held and used, second dropped, `err_ovf=1`. `err_clr` then returns it to 0.
- Reset mid-burst:
  - Stimulus: assert `sys_rst` while `reg_req=1`.
  - Response: all outputs at reset values in the same cycle. The next command after release decodes normally.
- Timeout (macro defined, `TIMEOUT_CYC=15`):
  - Stimulus: no `reg_ack`.
  - Response: `reg_req` drops after 15 cycles, `err_timeout=1`, state IDLE.
- Underrun:
  - Stimulus: pulse `tx_error` for 1 cycle.
  - Response: `err_underrun=1` until `err_clr`.
